reg_alu_seq: RTL and testbench
==============================

# reg_alu_seq

Multi-cycle sequencer that drives the shared register-file/ALU datapath from a valid/ready command port. Each command selects two source registers, a destination register and an ALU operation, and executes 1 to 16 times back-to-back. The repeat form supports accumulation patterns such as rd = rd + rb, and iteration can optionally stop early on overflow. The block replaces switch-driven addressing: it owns every register-file address, the write enable and the ALU operation, and it samples the ALU flags.

## Interface
- No parameters. Data width is 32 (register file), addresses are 5 bits, and the opcode is 4 bits.
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  4  ALU operation code, passed through opaquely
- cmd_ra  in  5  source A register address
- cmd_rb  in  5  source B register address
- cmd_rd  in  5  destination register address
- cmd_rep  in  4  repeat count; executes cmd_rep+1 times
- cmd_stop_of  in  1  end early after any iteration whose OF=1
- reg_r_addr_a  out  5  register-file read address A
- reg_r_addr_b  out  5  register-file read address B
- reg_w_addr  out  5  register-file write address
- reg_we  out  1  register-file write enable
- alu_op  out  4  ALU operation select
- alu_zf  in  1  ALU zero flag (combinational from current operands)
- alu_of  in  1  ALU overflow flag
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion
- zf_q  out  1  ZF sampled on the last executed iteration
- of_q  out  1  OF sampled on the last executed iteration
- aborted  out  1  last command ended early on overflow
- iter_cnt  out  5  iterations executed by the current or last command (1..16)

## Operation
- Datapath contract:
  - Register-file reads are combinational.
  - The write is committed on the clk edge while reg_we=1.
  - The ALU is combinational from the read data; its result feeds the write port directly.
- States: IDLE, RUN, GAP, DONE.
- IDLE:
  - cmd_ready=1 (forced 0 while rst=1).
  - An accept is cmd_valid & cmd_ready on a rising edge.
  - On accept: latch op/ra/rb/rd/rep/stop_of, clear iter_cnt, zf_q, of_q and aborted, then go to RUN.
- RUN (exactly one cycle):
  - reg_we=1; addresses and alu_op are driven from the latched values.
  - On the edge leaving RUN:
    - the register file writes;
    - zf_q←alu_zf and of_q←alu_of;
    - iter_cnt increments.
  - Next state is GAP.
- GAP (one cycle):
  - reg_we=0. Exists so that a write to rd is visible when rd==ra or rd==rb in the next iteration.
  - If remaining count = 0, go to DONE.
  - Else if stop_of & of_q, set aborted=1 and go to DONE.
  - Else decrement remaining count and go to RUN.
- DONE (one cycle): done=1, then go to IDLE.
- busy=1 in RUN, GAP and DONE; cmd_ready=0 in those states.
- reg_r_addr_a, reg_r_addr_b, reg_w_addr and alu_op hold the latched command values in all states, including IDLE after completion.
- reg_we = (state==RUN) & ~rst.
- Flags and iter_cnt hold until the next accept.
- A command with cmd_valid asserted while busy is not accepted. The requester must hold it stable until cmd_ready.
- An overflowing result is still written; abort only suppresses later iterations.
- cmd_rep=0 means one iteration. cmd_rep=15 means 16 iterations, giving iter_cnt=16, so the counter needs no wrap.

## Timing
- Reset values: state=IDLE; all address and op outputs 0; reg_we=0; busy, done, zf_q, of_q and aborted 0; iter_cnt=0.
- cmd_ready=1 in the first cycle after rst deasserts.
- Latency for N=cmd_rep+1 iterations, with the accept edge at cycle 0:
  - RUN occurs at cycles 1, 3, …, 2N−1.
  - done is high at cycle 2N+1.
  - cmd_ready is high again at cycle 2N+2.
- Minimum command spacing is 2N+2 cycles.
- Abort after iteration k: done is high at cycle 2k+1.
- rst asserted in any state:
  - reg_we=0 in that same cycle, so no write occurs.
  - All registers take their reset values on that edge.
  - An in-flight command is dropped with no done pulse.
- rst has priority over a simultaneous accept.

## Test plan
- Single op: after reset, send op=4'h2, ra=1, rb=2, rd=3, rep=0, with the bench ALU returning zf=1 and of=0.
  - Expect reg_we high only at cycle 1, with w_addr=3, a=1, b=2.
  - Expect done at cycle 3 with zf_q=1, of_q=0, iter_cnt=1, aborted=0.
- Accumulate: bench ALU model adds; r5=10, r6=3. Send ra=5, rb=6, rd=5, rep=3.
  - Expect four writes, at cycles 1, 3, 5 and 7.
  - Expect r5=22 at the end, done at cycle 9, iter_cnt=4.
- Overflow abort: rep=7, stop_of=1, with the bench raising alu_of during the 3rd RUN.
  - Expect exactly 3 writes (the 3rd still written).
  - Expect done at cycle 7 with aborted=1, of_q=1, iter_cnt=3.
  - Repeat with stop_of=0: expect 8 writes and aborted=0.
- Back-pressure: hold cmd_valid high with a second command throughout the first.
  - Expect the second command accepted exactly at the cycle cmd_ready reasserts (2N+2).
  - Expect no write in between.
- Reset mid-command: start rep=15 and assert rst in the cycle of the 2nd RUN.
  - Expect reg_we=0 in that cycle, no done pulse, all outputs at reset values next cycle, and cmd_ready=1 after release.
- Max repeat: rep=15 without overflow. Expect 16 writes, iter_cnt=16, done at cycle 33.

Source files
------------

// File: rtl/reg_alu_seq.sv
// reg_alu_seq: command sequencer for the shared register-file/ALU datapath.
// Each accepted command runs RUN/GAP pairs cmd_rep+1 times (RUN writes,
// GAP lets the written value settle before the next read), optionally
// ending early after an iteration that overflowed, then pulses done.
module reg_alu_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_op,
   input  logic [4:0] cmd_ra,
   input  logic [4:0] cmd_rb,
   input  logic [4:0] cmd_rd,
   input  logic [3:0] cmd_rep,
   input  logic       cmd_stop_of,
   output logic [4:0] reg_r_addr_a,
   output logic [4:0] reg_r_addr_b,
   output logic [4:0] reg_w_addr,
   output logic       reg_we,
   output logic [3:0] alu_op,
   input  logic       alu_zf,
   input  logic       alu_of,
   output logic       busy,
   output logic       done,
   output logic       zf_q,
   output logic       of_q,
   output logic       aborted,
   output logic [4:0] iter_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] op_q;
   logic [4:0] ra_q;
   logic [4:0] rb_q;
   logic [4:0] rd_q;
   logic [3:0] rem;
   logic       stop_of_q;
   logic       accept;
   logic       last_iter;
   logic       abort_now;

   assign accept    = cmd_valid & cmd_ready;
   assign last_iter = (rem == 4'd0);
   assign abort_now = ~last_iter & stop_of_q & of_q;

   // Handshake and datapath control; reset masks anything that could write or signal.
   assign cmd_ready    = (state == IDLE) & ~rst;
   assign reg_we       = (state == RUN) & ~rst;
   assign done         = (state == DONE) & ~rst;
   assign busy         = (state != IDLE);
   assign reg_r_addr_a = ra_q;
   assign reg_r_addr_b = rb_q;
   assign reg_w_addr   = rd_q;
   assign alu_op       = op_q;

   // State register; reset wins over a simultaneous accept.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic: one RUN, then one GAP per iteration.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_valid) state_nxt = RUN;
         RUN:     state_nxt = GAP;
         GAP:     if (last_iter || abort_now) state_nxt = DONE;
                  else                        state_nxt = RUN;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Command latch, iteration bookkeeping and flag capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q      <= 4'd0;
         ra_q      <= 5'd0;
         rb_q      <= 5'd0;
         rd_q      <= 5'd0;
         rem       <= 4'd0;
         stop_of_q <= 1'b0;
         zf_q      <= 1'b0;
         of_q      <= 1'b0;
         aborted   <= 1'b0;
         iter_cnt  <= 5'd0;
      end else begin
         if (accept) begin
            op_q      <= cmd_op;
            ra_q      <= cmd_ra;
            rb_q      <= cmd_rb;
            rd_q      <= cmd_rd;
            rem       <= cmd_rep;
            stop_of_q <= cmd_stop_of;
            zf_q      <= 1'b0;
            of_q      <= 1'b0;
            aborted   <= 1'b0;
            iter_cnt  <= 5'd0;
         end
         if (state == RUN) begin
            zf_q     <= alu_zf;
            of_q     <= alu_of;
            iter_cnt <= iter_cnt + 5'd1;
         end
         if (state == GAP) begin
            if (abort_now)       aborted <= 1'b1;
            else if (!last_iter) rem     <= rem - 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_reg_alu_seq.sv
// tb_reg_alu_seq: directed bench for reg_alu_seq with a small register file
// and adder ALU model. Cycle 0 is the accept edge; cycle n is sampled 1ns
// after the n-th following rising edge.
module tb_reg_alu_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic [4:0]  cmd_ra;
   logic [4:0]  cmd_rb;
   logic [4:0]  cmd_rd;
   logic [3:0]  cmd_rep;
   logic        cmd_stop_of;
   logic [4:0]  reg_r_addr_a;
   logic [4:0]  reg_r_addr_b;
   logic [4:0]  reg_w_addr;
   logic        reg_we;
   logic [3:0]  alu_op;
   logic        alu_zf;
   logic        alu_of;
   logic        busy;
   logic        done;
   logic        zf_q;
   logic        of_q;
   logic        aborted;
   logic [4:0]  iter_cnt;

   logic [31:0] rf [32];
   logic [31:0] alu_res;
   logic        zf_ovr;
   logic        of_ovr;
   logic        pre_we;
   logic [4:0]  pre_addr;
   logic [31:0] pre_data;
   int          wr_total;
   int          nvec;
   int          nerr;

   always #5 clk = ~clk;

   reg_alu_seq dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
      .cmd_rep(cmd_rep), .cmd_stop_of(cmd_stop_of),
      .reg_r_addr_a(reg_r_addr_a), .reg_r_addr_b(reg_r_addr_b),
      .reg_w_addr(reg_w_addr), .reg_we(reg_we), .alu_op(alu_op),
      .alu_zf(alu_zf), .alu_of(alu_of), .busy(busy), .done(done),
      .zf_q(zf_q), .of_q(of_q), .aborted(aborted), .iter_cnt(iter_cnt)
   );

   // Combinational adder ALU on combinational register-file reads.
   assign alu_res = rf[reg_r_addr_a] + rf[reg_r_addr_b];
   assign alu_zf  = zf_ovr | (alu_res == 32'd0);
   assign alu_of  = of_ovr;

   // Register file write port plus a bench preload path.
   always @(posedge clk) begin
      if (reg_we) begin
         rf[reg_w_addr] <= alu_res;
         wr_total       <= wr_total + 1;
      end else if (pre_we) begin
         rf[pre_addr] <= pre_data;
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [4:0] a, input logic [31:0] d);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      step;
      pre_we   = 1'b0;
   endtask

   // Present a command in IDLE and take the accept edge; returns at cycle 1.
   task automatic issue(input logic [3:0] op, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [4:0] rd, input logic [3:0] rep, input logic stop);
      cmd_op      = op;
      cmd_ra      = ra;
      cmd_rb      = rb;
      cmd_rd      = rd;
      cmd_rep     = rep;
      cmd_stop_of = stop;
      cmd_valid   = 1'b1;
      step;
      cmd_valid   = 1'b0;
   endtask

   // Observe from cycle 1 until done (bounded); raise alu_of during RUN number of_run.
   task automatic run_cmd(input int of_run, input int limit,
                          output int done_cyc, output int nwr, output int bad_we);
      done_cyc = -1;
      nwr      = 0;
      bad_we   = 0;
      for (int cyc = 1; cyc <= limit; cyc++) begin
         if (reg_we) begin
            nwr++;
            if (cyc % 2 == 0) bad_we++;
            of_ovr = (nwr == of_run);
         end
         if (done) begin
            done_cyc = cyc;
            break;
         end
         step;
      end
      of_ovr = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step;
      nvec++; if (cmd_ready !== 1'b0) begin nerr++; $display("FAIL reset_ready got %0b want 0", cmd_ready); end
      nvec++; if (reg_we !== 1'b0) begin nerr++; $display("FAIL reset_we got %0b want 0", reg_we); end
      step;
      rst = 1'b0;
      #1;
      nvec++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL post_reset_ready got %0b want 1", cmd_ready); end
      nvec++; if ({busy, done, zf_q, of_q, aborted} !== 5'b0) begin nerr++; $display("FAIL reset_flags got %b want 00000", {busy, done, zf_q, of_q, aborted}); end
      nvec++; if ({reg_r_addr_a, reg_r_addr_b, reg_w_addr, alu_op, iter_cnt} !== 24'd0) begin nerr++; $display("FAIL reset_addr_op_iter got %h want 0", {reg_r_addr_a, reg_r_addr_b, reg_w_addr, alu_op, iter_cnt}); end
      step;
   endtask

   task automatic test_single_op;
      int dc, nw, bw;
      zf_ovr = 1'b1;
      issue(4'h2, 5'd1, 5'd2, 5'd3, 4'd0, 1'b0);
      nvec++; if ({reg_we, reg_w_addr, reg_r_addr_a, reg_r_addr_b, alu_op} !== {1'b1, 5'd3, 5'd1, 5'd2, 4'h2}) begin nerr++; $display("FAIL single_run_outputs got %h want %h", {reg_we, reg_w_addr, reg_r_addr_a, reg_r_addr_b, alu_op}, {1'b1, 5'd3, 5'd1, 5'd2, 4'h2}); end
      nvec++; if ({busy, cmd_ready} !== 2'b10) begin nerr++; $display("FAIL single_busy_ready got %b want 10", {busy, cmd_ready}); end
      run_cmd(0, 10, dc, nw, bw);
      zf_ovr = 1'b0;
      nvec++; if (dc != 3) begin nerr++; $display("FAIL single_done_cycle got %0d want 3", dc); end
      nvec++; if (nw != 1 || bw != 0) begin nerr++; $display("FAIL single_writes got %0d (bad %0d) want 1 (bad 0)", nw, bw); end
      nvec++; if ({zf_q, of_q, aborted} !== 3'b100) begin nerr++; $display("FAIL single_flags got %b want 100", {zf_q, of_q, aborted}); end
      nvec++; if (iter_cnt !== 5'd1) begin nerr++; $display("FAIL single_iter got %0d want 1", iter_cnt); end
      step;
      nvec++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL single_ready_again got %0b want 1", cmd_ready); end
      nvec++; if ({reg_w_addr, alu_op, zf_q, iter_cnt} !== {5'd3, 4'h2, 1'b1, 5'd1}) begin nerr++; $display("FAIL single_hold got %h want %h", {reg_w_addr, alu_op, zf_q, iter_cnt}, {5'd3, 4'h2, 1'b1, 5'd1}); end
   endtask

   task automatic test_accumulate;
      int dc, nw, bw;
      preload(5'd5, 32'd10);
      preload(5'd6, 32'd3);
      issue(4'h0, 5'd5, 5'd6, 5'd5, 4'd3, 1'b0);
      run_cmd(0, 20, dc, nw, bw);
      nvec++; if (dc != 9) begin nerr++; $display("FAIL accum_done_cycle got %0d want 9", dc); end
      nvec++; if (nw != 4 || bw != 0) begin nerr++; $display("FAIL accum_writes got %0d (bad %0d) want 4 (bad 0)", nw, bw); end
      nvec++; if (rf[5] !== 32'd22) begin nerr++; $display("FAIL accum_r5 got %0d want 22", rf[5]); end
      nvec++; if (iter_cnt !== 5'd4) begin nerr++; $display("FAIL accum_iter got %0d want 4", iter_cnt); end
      step;
   endtask

   task automatic test_overflow_abort;
      int dc, nw, bw;
      issue(4'h1, 5'd7, 5'd8, 5'd9, 4'd7, 1'b1);
      run_cmd(3, 30, dc, nw, bw);
      nvec++; if (dc != 7) begin nerr++; $display("FAIL abort_done_cycle got %0d want 7", dc); end
      nvec++; if (nw != 3 || bw != 0) begin nerr++; $display("FAIL abort_writes got %0d (bad %0d) want 3 (bad 0)", nw, bw); end
      nvec++; if ({aborted, of_q} !== 2'b11) begin nerr++; $display("FAIL abort_flags got %b want 11", {aborted, of_q}); end
      nvec++; if (iter_cnt !== 5'd3) begin nerr++; $display("FAIL abort_iter got %0d want 3", iter_cnt); end
      step;
      issue(4'h1, 5'd7, 5'd8, 5'd9, 4'd7, 1'b0);
      run_cmd(3, 30, dc, nw, bw);
      nvec++; if (dc != 17) begin nerr++; $display("FAIL noabort_done_cycle got %0d want 17", dc); end
      nvec++; if (nw != 8 || bw != 0) begin nerr++; $display("FAIL noabort_writes got %0d (bad %0d) want 8 (bad 0)", nw, bw); end
      nvec++; if ({aborted, of_q, iter_cnt} !== {1'b0, 1'b0, 5'd8}) begin nerr++; $display("FAIL noabort_state got %b want 0001000", {aborted, of_q, iter_cnt}); end
      step;
   endtask

   task automatic test_back_to_back;
      int dc, nw, bw;
      cmd_op = 4'h3; cmd_ra = 5'd1; cmd_rb = 5'd2; cmd_rd = 5'd10; cmd_rep = 4'd1; cmd_stop_of = 1'b0;
      cmd_valid = 1'b1;
      step;
      cmd_op = 4'h4; cmd_rd = 5'd11; cmd_rep = 4'd0;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         nvec++; if (reg_we !== (cyc == 1 || cyc == 3)) begin nerr++; $display("FAIL bp_we_c%0d got %0b want %0b", cyc, reg_we, (cyc == 1 || cyc == 3)); end
         nvec++; if (cmd_ready !== (cyc == 6)) begin nerr++; $display("FAIL bp_ready_c%0d got %0b want %0b", cyc, cmd_ready, (cyc == 6)); end
         nvec++; if (done !== (cyc == 5)) begin nerr++; $display("FAIL bp_done_c%0d got %0b want %0b", cyc, done, (cyc == 5)); end
         nvec++; if (reg_w_addr !== 5'd10) begin nerr++; $display("FAIL bp_waddr_c%0d got %0d want 10", cyc, reg_w_addr); end
         step;
      end
      cmd_valid = 1'b0;
      nvec++; if ({reg_we, reg_w_addr, alu_op} !== {1'b1, 5'd11, 4'h4}) begin nerr++; $display("FAIL bp_second_run got %h want %h", {reg_we, reg_w_addr, alu_op}, {1'b1, 5'd11, 4'h4}); end
      run_cmd(0, 10, dc, nw, bw);
      nvec++; if (dc != 3 || nw != 1) begin nerr++; $display("FAIL bp_second_done got cycle %0d writes %0d want cycle 3 writes 1", dc, nw); end
      step;
   endtask

   task automatic test_reset_mid;
      int snap;
      issue(4'h5, 5'd1, 5'd2, 5'd12, 4'd15, 1'b0);
      step;
      step;
      nvec++; if (reg_we !== 1'b1) begin nerr++; $display("FAIL rmid_second_run got %0b want 1", reg_we); end
      rst = 1'b1;
      #1;
      nvec++; if ({reg_we, cmd_ready} !== 2'b00) begin nerr++; $display("FAIL rmid_we_ready got %b want 00", {reg_we, cmd_ready}); end
      snap = wr_total;
      step;
      rst = 1'b0;
      #1;
      nvec++; if (wr_total != snap) begin nerr++; $display("FAIL rmid_no_write got %0d want %0d", wr_total, snap); end
      nvec++; if ({busy, done, reg_we, zf_q, of_q, aborted} !== 6'b0) begin nerr++; $display("FAIL rmid_flags got %b want 000000", {busy, done, reg_we, zf_q, of_q, aborted}); end
      nvec++; if ({reg_r_addr_a, reg_r_addr_b, reg_w_addr, alu_op, iter_cnt} !== 24'd0) begin nerr++; $display("FAIL rmid_addr_iter got %h want 0", {reg_r_addr_a, reg_r_addr_b, reg_w_addr, alu_op, iter_cnt}); end
      nvec++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL rmid_ready got %0b want 1", cmd_ready); end
      for (int i = 0; i < 4; i++) begin
         step;
         nvec++; if ({done, busy} !== 2'b00) begin nerr++; $display("FAIL rmid_quiet_%0d got %b want 00", i, {done, busy}); end
      end
   endtask

   task automatic test_max_repeat;
      int dc, nw, bw;
      issue(4'h6, 5'd1, 5'd2, 5'd13, 4'd15, 1'b1);
      run_cmd(0, 40, dc, nw, bw);
      nvec++; if (dc != 33) begin nerr++; $display("FAIL max_done_cycle got %0d want 33", dc); end
      nvec++; if (nw != 16 || bw != 0) begin nerr++; $display("FAIL max_writes got %0d (bad %0d) want 16 (bad 0)", nw, bw); end
      nvec++; if ({iter_cnt, aborted} !== {5'd16, 1'b0}) begin nerr++; $display("FAIL max_iter got %0d aborted %0b want 16 aborted 0", iter_cnt, aborted); end
      step;
      nvec++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL max_ready_again got %0b want 1", cmd_ready); end
   endtask

   initial begin
      nvec = 0; nerr = 0; wr_total = 0;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_ra = 5'd0; cmd_rb = 5'd0;
      cmd_rd = 5'd0; cmd_rep = 4'd0; cmd_stop_of = 1'b0;
      zf_ovr = 1'b0; of_ovr = 1'b0; pre_we = 1'b0; pre_addr = 5'd0; pre_data = 32'd0;
      test_reset;
      test_single_op;
      test_accumulate;
      test_overflow_abort;
      test_back_to_back;
      test_reset_mid;
      test_max_repeat;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
